// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the neural-network datapath: word geometry,
// activation selectors and the saturating shift used to rescale accumulator sums.
package nn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int INT_WIDTH  = 4;
  localparam int FRAC       = DATA_WIDTH - 1 - INT_WIDTH;

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRAC;

  localparam string ACT_RELU         = "relu";
  localparam string ACT_SIGMOID_FULL = "sigmoid_full";
  localparam string ACT_SIGMOID_HALF = "sigmoid_half";

  // Wide enough to hold any accumulator this package is likely to see.
  typedef logic signed [63:0] wide_t;

  // Arithmetic right shift, then clamp into the signed range of 'width' bits.
  function automatic wide_t sat_shift(input wide_t v, input int shift, input int width);
    wide_t s;
    wide_t hi;
    wide_t lo;
    s  = v >>> shift;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/sigmoid_rom.sv
// Synchronous-read sigmoid table. CENTERED tables span [-2^(AW-1), 2^(AW-1)) address
// steps around zero; uncentered tables hold only the non-negative half.
module sigmoid_rom #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12,
  parameter int FRAC       = 11,
  parameter int ADDR_FRAC  = 6,
  parameter bit CENTERED   = 1'b1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Table contents are fixed at elaboration: round(sigmoid(x) * 2^FRAC).
  function automatic logic [DATA_WIDTH-1:0] entry(input int k);
    real x;
    x = real'(CENTERED ? k - DEPTH / 2 : k) / real'(1 << ADDR_FRAC);
    return DATA_WIDTH'($rtoi(real'(1 << FRAC) / (1.0 + $exp(-x)) + 0.5));
  endfunction

  logic [DATA_WIDTH-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_table
    assign rom[k] = entry(k);
  end

  // NOTE: the table and its read register carry no reset so the tools can map them
  // onto block ROM; the owner masks the output until the first valid read.
  always_ff @(posedge clk) begin
    if (en) data <= rom[addr];
  end

endmodule

// File: rtl/neuron_activation_unit.sv
// One-cycle registered activation stage: maps a signed Q(2*FRAC) accumulator sum to a
// Q(FRAC) activation using ReLU or a sigmoid table selected by ACT_TYPE.
module neuron_activation_unit #(
  parameter int    DATA_WIDTH   = nn_pkg::DATA_WIDTH,
  parameter int    INT_WIDTH    = nn_pkg::INT_WIDTH,
  parameter string ACT_TYPE     = nn_pkg::ACT_RELU,
  parameter int    SIGMOID_SIZE = 10,
  parameter int    ADDR_FRAC    = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [2*DATA_WIDTH-1:0] sum,
  output logic        [DATA_WIDTH-1:0]   out,
  output logic                           out_valid
);

  import nn_pkg::wide_t;
  import nn_pkg::sat_shift;
  import nn_pkg::ACT_RELU;
  import nn_pkg::ACT_SIGMOID_FULL;
  import nn_pkg::ACT_SIGMOID_HALF;

  localparam int FRAC_BITS = DATA_WIDTH - 1 - INT_WIDTH;

  if (SIGMOID_SIZE < 2 || ADDR_FRAC < 0 || ADDR_FRAC > 2 * FRAC_BITS) begin : g_bad_geometry
    $error("neuron_activation_unit: inconsistent SIGMOID_SIZE/ADDR_FRAC");
  end

  wide_t sum_w;
  assign sum_w = wide_t'(sum);

  if (ACT_TYPE == ACT_RELU) begin : g_relu

    wide_t                 relu_sat;
    logic [DATA_WIDTH-1:0] relu_val;

    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
      relu_sat = sat_shift(sum_w, FRAC_BITS, DATA_WIDTH);
      relu_val = (sum_w < 0) ? '0 : DATA_WIDTH'(relu_sat);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out       <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out <= relu_val;
      end
    end

  end else if (ACT_TYPE == ACT_SIGMOID_FULL || ACT_TYPE == ACT_SIGMOID_HALF) begin : g_sigmoid

    localparam bit    HALF      = (ACT_TYPE == ACT_SIGMOID_HALF);
    localparam int    AW        = HALF ? SIGMOID_SIZE - 1 : SIGMOID_SIZE;
    localparam int    ROM_WIDTH = FRAC_BITS + 1;
    localparam wide_t M_MAX     = (wide_t'(1) <<< AW) - wide_t'(1);
    localparam logic [ROM_WIDTH-1:0] ROM_ONE = {1'b1, {FRAC_BITS{1'b0}}};

    wide_t                a;
    wide_t                a_mag;
    logic [AW-1:0]        addr;
    logic [ROM_WIDTH-1:0] rom_q;
    logic [ROM_WIDTH-1:0] rom_out;
    logic                 loaded;
    logic                 neg;

    // Full table is indexed by a + 2^(AW-1), i.e. the two's-complement address with
    // its MSB flipped; the half table by |a| clamped to its top entry.
    always_comb begin
      a     = sat_shift(sum_w, 2 * FRAC_BITS - ADDR_FRAC, SIGMOID_SIZE);
      a_mag = (a < 0) ? -a : a;
      if (HALF) addr = (a_mag > M_MAX) ? AW'(M_MAX) : AW'(a_mag);
      else      addr = AW'(a) ^ {1'b1, {(AW - 1){1'b0}}};
    end

    sigmoid_rom #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (ROM_WIDTH),
      .FRAC       (FRAC_BITS),
      .ADDR_FRAC  (ADDR_FRAC),
      .CENTERED   (!HALF)
    ) u_rom (
      .clk  (clk),
      .en   (in_valid),
      .addr (addr),
      .data (rom_q)
    );

    // 'loaded' keeps the unreset table register hidden until a result has been read.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        loaded    <= 1'b0;
        neg       <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          loaded <= 1'b1;
          neg    <= (sum_w < 0);
        end
      end
    end

    // Half table relies on sigmoid(-x) = 1 - sigmoid(x).
    always_comb begin
      rom_out = (HALF && neg) ? ROM_ONE - rom_q : rom_q;
      out     = loaded ? DATA_WIDTH'(rom_out) : '0;
    end

  end else begin : g_bad_act
    $error("neuron_activation_unit: unsupported ACT_TYPE %s", ACT_TYPE);
  end

endmodule

// File: tb/tb_neuron_activation_unit.sv
// Self-checking bench driving one shared stimulus stream into relu, sigmoid_full and
// sigmoid_half instances and comparing each against an arithmetic reference.
module tb_neuron_activation_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] sum;

  logic [15:0] out_relu, out_full, out_half;
  logic        v_relu, v_full, v_half;

  logic [15:0] m_relu, m_full, m_half;
  logic        m_valid;

  int checks   = 0;
  int failures = 0;

  neuron_activation_unit #(.ACT_TYPE("relu")) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_relu), .out_valid(v_relu)
  );
  neuron_activation_unit #(.ACT_TYPE("sigmoid_full")) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_full), .out_valid(v_full)
  );
  neuron_activation_unit #(.ACT_TYPE("sigmoid_half")) u_half (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_half), .out_valid(v_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: Q22 sum in, Q11 activation out.
  function automatic logic [15:0] ref_relu(input logic [31:0] s);
    longint v = longint'(signed'(s));
    if (v < 0) return 16'h0000;
    v = v / 2048;
    return (v > 32767) ? 16'h7FFF : 16'(v);
  endfunction

  function automatic longint ref_addr(input logic [31:0] s);
    longint v = longint'(signed'(s));
    longint a = v / 65536;
    if (v < 0 && (v % 65536) != 0) a = a - 1;
    if (a > 511)  a = 511;
    if (a < -512) a = -512;
    return a;
  endfunction

  function automatic int sig_q(input real x);
    return $rtoi(2048.0 / (1.0 + $exp(-x)) + 0.5);
  endfunction

  function automatic logic [15:0] ref_full(input logic [31:0] s);
    return 16'(sig_q(real'(ref_addr(s)) / 64.0));
  endfunction

  function automatic logic [15:0] ref_half(input logic [31:0] s);
    longint a = ref_addr(s);
    longint m = (a < 0) ? -a : a;
    int     r;
    if (m > 511) m = 511;
    r = sig_q(real'(m) / 64.0);
    return (signed'(s) < 0) ? 16'(2048 - r) : 16'(r);
  endfunction

  function automatic logic [31:0] rand_sum();
    logic [31:0] edges [8];
    edges = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h01FF_FFFF, 32'h0200_0000,
              32'hFE00_0000, 32'hFDFF_FFFF, 32'h03FF_FFFF, 32'h0400_0000};
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'(int'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000);
      2:       return 32'($urandom_range(0, 32'h03FF_FFFF));
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_relu_valid"}, 32'(v_relu), 32'(m_valid));
    check({tag, "_full_valid"}, 32'(v_full), 32'(m_valid));
    check({tag, "_half_valid"}, 32'(v_half), 32'(m_valid));
    check({tag, "_relu_out"},   32'(out_relu), 32'(m_relu));
    check({tag, "_full_out"},   32'(out_full), 32'(m_full));
    check({tag, "_half_out"},   32'(out_half), 32'(m_half));
  endtask

  task automatic clear_model();
    m_relu  = '0;
    m_full  = '0;
    m_half  = '0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle on the falling edge, check the registered result after the rise.
  task automatic step(input logic v, input logic [31:0] s, input string tag);
    @(negedge clk);
    in_valid = v;
    sum      = s;
    m_valid  = v;
    if (v) begin
      m_relu = ref_relu(s);
      m_full = ref_full(s);
      m_half = ref_half(s);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    sum      = $urandom();
    clear_model();

    // Reset holds everything at zero even with traffic on the inputs.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");

    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sum      = $urandom();
    @(posedge clk);
    #1;
    check_all("release_idle");

    step(1'b1, 32'h0040_0000, "pos_one");
    check("relu_pos_one", 32'(out_relu), 32'h0800);
    check("full_pos_one", 32'(out_full), 32'h05D9);
    check("half_pos_one", 32'(out_half), 32'h05D9);

    step(1'b1, 32'hFFC0_0000, "neg_one");
    check("relu_neg_one", 32'(out_relu), 32'h0000);
    check("half_neg_one", 32'(out_half), 32'h0227);

    step(1'b1, 32'h7FFF_FFFF, "max");
    check("relu_max", 32'(out_relu), 32'h7FFF);
    check("full_max", 32'(out_full), 32'h07FF);
    check("half_max", 32'(out_half), 32'h07FF);

    step(1'b1, 32'h0000_0000, "zero");
    check("full_zero", 32'(out_full), 32'h0400);
    check("relu_zero", 32'(out_relu), 32'h0000);

    step(1'b1, 32'h8000_0000, "min");
    check("half_min", 32'(out_half), 32'h0001);
    check("relu_min", 32'(out_relu), 32'h0000);

    // Unknown sum while idle must leave the held result untouched.
    step(1'b0, 'x, "x_idle");
    step(1'b0, $urandom(), "idle_hold");

    for (int i = 0; i < 8; i++) step(1'b1, rand_sum(), "stream");
    step(1'b0, $urandom(), "stream_gap0");
    step(1'b0, $urandom(), "stream_gap1");

    for (int i = 0; i < 60; i++) step(($urandom_range(0, 3) != 0), rand_sum(), "random");

    // Asynchronous reset between edges in the middle of a burst.
    step(1'b1, rand_sum(), "pre_rst0");
    step(1'b1, rand_sum(), "pre_rst1");
    #2;
    rst = 1'b0;
    clear_model();
    #1;
    check_all("async_rst");

    @(negedge clk);
    in_valid = 1'b1;
    sum      = rand_sum();
    @(posedge clk);
    #1;
    check_all("in_rst");

    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst");

    step(1'b0, $urandom(), "post_rst_idle");
    step(1'b1, rand_sum(), "resume0");
    step(1'b1, rand_sum(), "resume1");
    step(1'b0, $urandom(), "resume_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
